rf_wb_arbiter: RTL and testbench

Write-port arbiter and scheduler for the integer register file, placed between the WB stage, the multi-cycle unit (MDU: mul/div) and the register file. The WB stage has fixed priority and is never stalled. MDU results are held in a one-entry buffer and written in a free cycle. An anti-starvation counter requests a pipeline bubble, and an optional scoreboard flags reads of registers with an MDU result still in flight.

---
 rtl/rf_wb_arbiter_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg
//   Shared definitions for the register-file write-port arbiter:
//   default widths, the default starvation limit, the MDU buffer FSM
//   state encoding and a saturating increment helper.
package rf_wb_arbiter_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int RF_AW_DEF        = 5;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } buf_state_e;

  // Increment v, stopping at lim.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Busy vector for registers whose MDU result is still in flight.
//   Ports:
//     clk, rst            clock, synchronous active-low reset
//     set_en, set_addr    mark a register busy at the edge
//     clr_en, clr_addr    mark a register free at the edge (set wins)
//     rd_addr1/2          read addresses
//     busy1/2             busy bit of each read address
//   Callers never set register 0, so busy[0] stays 0.
module rf_scoreboard #(
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [RF_AW-1:0] set_addr,
  input  logic             clr_en,
  input  logic [RF_AW-1:0] clr_addr,
  input  logic [RF_AW-1:0] rd_addr1,
  input  logic [RF_AW-1:0] rd_addr2,
  output logic             busy1,
  output logic             busy2
);

  localparam int NREG = 2 ** RF_AW;

  logic [NREG-1:0] busy_q;

  // Clear is written before set, so a same-cycle set of the same
  // register overrides the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      if (clr_en) busy_q[clr_addr] <= 1'b0;
      if (set_en) busy_q[set_addr] <= 1'b1;
    end
  end

  assign busy1 = busy_q[rd_addr1];
  assign busy2 = busy_q[rd_addr2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-port arbiter for the integer register file. The WB stage has
//   fixed priority and 0-cycle latency; MDU results sit in a one-entry
//   buffer and are written in the first cycle without a live WB write.
//   A starvation counter requests a pipeline bubble (stall_req) once the
//   buffer has been blocked for STARVE_LIMIT cycles.
//   Optional feature macro: RF_WB_SCOREBOARD_EN -- tracks registers with
//   an MDU result in flight and raises hazard on ID-stage reads of them.
//   Without it, hazard is tied 0.
//   Ports:
//     clk, rst                        clock, synchronous active-low reset
//     wb_reg_wen/waddr/wdata          WB stage write
//     mdu_valid/ready/waddr/wdata     MDU result handshake
//     issue_mdu, issue_waddr          MDU op issue (scoreboard set)
//     rd_addr1, rd_addr2, hazard      ID source registers, busy flag
//     stall_req                       bubble request
//     rf_wen/waddr/wdata              register file write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int RF_AW        = RF_AW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_reg_wen,
  input  logic [RF_AW-1:0] wb_reg_waddr,
  input  logic [XLEN-1:0]  wb_reg_wdata,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [RF_AW-1:0] mdu_waddr,
  input  logic [XLEN-1:0]  mdu_wdata,
  input  logic             issue_mdu,
  input  logic [RF_AW-1:0] issue_waddr,
  input  logic [RF_AW-1:0] rd_addr1,
  input  logic [RF_AW-1:0] rd_addr2,
  output logic             hazard,
  output logic             stall_req,
  output logic             rf_wen,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  buf_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [RF_AW-1:0] buf_addr_q;
  logic [XLEN-1:0]  buf_data_q;

  logic wb_live, buf_valid, capture, drain;

  assign wb_live   = wb_reg_wen && (wb_reg_waddr != '0);
  assign buf_valid = (state_q != IDLE);

  // mdu_ready is low whenever the buffer is full, so capture and drain
  // are mutually exclusive. A handshake to x0 is consumed but not kept.
  assign mdu_ready = rst && !buf_valid;
  assign capture   = mdu_ready && mdu_valid && (mdu_waddr != '0);
  assign drain     = rst && buf_valid && !wb_live;
  assign stall_req = rst && (state_q == FORCE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (capture) state_d = HOLD;
      end
      HOLD: begin
        if (drain) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q, LIMIT);
          if (cnt_d == LIMIT) state_d = FORCE;
        end
      end
      FORCE: begin
        if (drain) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q, LIMIT);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        buf_addr_q <= mdu_waddr;
        buf_data_q <= mdu_wdata;
      end
    end
  end

  // WB wins; the buffer only drives the port when WB is not live.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rst && wb_live) begin
      rf_wen   = 1'b1;
      rf_waddr = wb_reg_waddr;
      rf_wdata = wb_reg_wdata;
    end else if (drain) begin
      rf_wen   = 1'b1;
      rf_waddr = buf_addr_q;
      rf_wdata = buf_data_q;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic busy1, busy2;

  rf_scoreboard #(.RF_AW(RF_AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_mdu && (issue_waddr != '0)),
    .set_addr (issue_waddr),
    .clr_en   (drain),
    .clr_addr (buf_addr_q),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  assign hazard = rst && (busy1 || busy2);
`else
  // Ordering is enforced upstream by blocking MDU issue.
  logic unused_sb;
  assign unused_sb = ^{issue_mdu, issue_waddr, rd_addr1, rd_addr2};
  assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;
  localparam int LIMIT = 4;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_reg_wen;
  logic [RF_AW-1:0] wb_reg_waddr;
  logic [XLEN-1:0]  wb_reg_wdata;
  logic             mdu_valid;
  logic             mdu_ready;
  logic [RF_AW-1:0] mdu_waddr;
  logic [XLEN-1:0]  mdu_wdata;
  logic             issue_mdu;
  logic [RF_AW-1:0] issue_waddr;
  logic [RF_AW-1:0] rd_addr1, rd_addr2;
  logic             hazard, stall_req, rf_wen;
  logic [RF_AW-1:0] rf_waddr;
  logic [XLEN-1:0]  rf_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .RF_AW(RF_AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .issue_mdu(issue_mdu), .issue_waddr(issue_waddr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard(hazard), .stall_req(stall_req),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Reference model: a held result (valid/addr/data), a count of cycles it
  // has been blocked, and a per-register in-flight flag.
  bit              m_bv;
  logic [RF_AW-1:0] m_ba;
  logic [XLEN-1:0] m_bd;
  int              m_blk;
  bit              m_busy [32];

  logic             e_ready, e_stall, e_haz, e_wen;
  logic [RF_AW-1:0] e_waddr;
  logic [XLEN-1:0]  e_wdata;

  function automatic bit wb_is_live();
    return wb_reg_wen && (wb_reg_waddr != 0);
  endfunction

  task automatic model_eval();
    bit dr;
    e_ready = 0; e_stall = 0; e_haz = 0; e_wen = 0; e_waddr = 0; e_wdata = 0;
    if (rst) begin
      dr      = m_bv && !wb_is_live();
      e_ready = !m_bv;
      e_stall = m_bv && (m_blk >= LIMIT);
      e_haz   = SB && (m_busy[rd_addr1] || m_busy[rd_addr2]);
      if (wb_is_live()) begin
        e_wen = 1; e_waddr = wb_reg_waddr; e_wdata = wb_reg_wdata;
      end else if (dr) begin
        e_wen = 1; e_waddr = m_ba; e_wdata = m_bd;
      end
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      m_bv = 0; m_blk = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      if (m_bv && !wb_is_live()) begin
        m_bv = 0; m_blk = 0; m_busy[m_ba] = 0;
      end else if (m_bv) begin
        m_blk = (m_blk + 1 > LIMIT) ? LIMIT : m_blk + 1;
      end else if (mdu_valid && mdu_waddr != 0) begin
        m_bv = 1; m_ba = mdu_waddr; m_bd = mdu_wdata;
      end
      if (issue_mdu && issue_waddr != 0) m_busy[issue_waddr] = 1;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_reg_wen = 0; wb_reg_waddr = 0; wb_reg_wdata = 0;
    mdu_valid = 0; mdu_waddr = 0; mdu_wdata = 0;
    issue_mdu = 0; issue_waddr = 0; rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; wb_reg_wen = 1; wb_reg_waddr = 3; mdu_valid = 1; mdu_waddr = 6;
    #1;
    tick(); tick();
    n_checks++; if (mdu_ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", mdu_ready); else n_pass++;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall_req); else n_pass++;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got=%0b exp=0", rf_wen); else n_pass++;
    n_checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard got=%0b exp=0", hazard); else n_pass++;
    idle_inputs(); rst = 1; #1;
    n_checks++; if (mdu_ready !== 1'b1) $display("FAIL reset_release_ready got=%0b exp=1", mdu_ready); else n_pass++;
    tick();
  endtask

  task automatic test_mdu_only();
    mdu_valid = 1; mdu_waddr = 5; mdu_wdata = 32'hDEADBEEF; #1;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL mdu_n_rf_wen got=%0b exp=0", rf_wen); else n_pass++;
    tick();
    mdu_valid = 0; #1;
    n_checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL mdu_n1_write got=%0b/%0d/%h exp=1/5/deadbeef", rf_wen, rf_waddr, rf_wdata); else n_pass++;
    n_checks++; if (mdu_ready !== 1'b0) $display("FAIL mdu_n1_ready got=%0b exp=0", mdu_ready); else n_pass++;
    tick(); #1;
    n_checks++; if (mdu_ready !== 1'b1) $display("FAIL mdu_n2_ready got=%0b exp=1", mdu_ready); else n_pass++;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL mdu_n2_rf_wen got=%0b exp=0", rf_wen); else n_pass++;
  endtask

  task automatic test_collision();
    wb_reg_wen = 1; wb_reg_waddr = 3; wb_reg_wdata = 32'h11;
    mdu_valid = 1; mdu_waddr = 7; mdu_wdata = 32'h22;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
        $display("FAIL coll_wb_write c=%0d got=%0b/%0d/%h exp=1/3/11", c, rf_wen, rf_waddr, rf_wdata); else n_pass++;
      n_checks++; if (mdu_ready !== (c == 0))
        $display("FAIL coll_ready c=%0d got=%0b exp=%0b", c, mdu_ready, (c == 0)); else n_pass++;
      tick();
      mdu_valid = 0;
    end
    wb_reg_wen = 0; #1;
    n_checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h22})
      $display("FAIL coll_mdu_write got=%0b/%0d/%h exp=1/7/22", rf_wen, rf_waddr, rf_wdata); else n_pass++;
    n_checks++; if (mdu_ready !== 1'b0) $display("FAIL coll_drain_ready got=%0b exp=0", mdu_ready); else n_pass++;
    tick(); #1;
    n_checks++; if (mdu_ready !== 1'b1) $display("FAIL coll_after_ready got=%0b exp=1", mdu_ready); else n_pass++;
  endtask

  task automatic test_starvation();
    wb_reg_wen = 1; wb_reg_waddr = 4; wb_reg_wdata = 32'h44;
    mdu_valid = 1; mdu_waddr = 8; mdu_wdata = 32'h88;
    tick(); mdu_valid = 0;
    for (int c = 1; c <= LIMIT; c++) begin
      #1;
      n_checks++; if (stall_req !== 1'b0) $display("FAIL starve_early c=%0d got=%0b exp=0", c, stall_req); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (stall_req !== 1'b1) $display("FAIL starve_stall got=%0b exp=1", stall_req); else n_pass++;
    tick();
    wb_reg_wen = 0; #1;
    n_checks++; if (stall_req !== 1'b1) $display("FAIL starve_drain_stall got=%0b exp=1", stall_req); else n_pass++;
    n_checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88})
      $display("FAIL starve_drain_write got=%0b/%0d/%h exp=1/8/88", rf_wen, rf_waddr, rf_wdata); else n_pass++;
    tick(); #1;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL starve_release got=%0b exp=0", stall_req); else n_pass++;
  endtask

  task automatic test_x0();
    wb_reg_wen = 1; wb_reg_waddr = 0; wb_reg_wdata = 32'h55; #1;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL x0_wb got=%0b exp=0", rf_wen); else n_pass++;
    wb_reg_wen = 0; mdu_valid = 1; mdu_waddr = 0; mdu_wdata = 32'h66; #1;
    n_checks++; if (mdu_ready !== 1'b1) $display("FAIL x0_mdu_accept got=%0b exp=1", mdu_ready); else n_pass++;
    tick(); mdu_valid = 0; #1;
    n_checks++; if (mdu_ready !== 1'b1) $display("FAIL x0_mdu_ready got=%0b exp=1", mdu_ready); else n_pass++;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL x0_mdu_write got=%0b exp=0", rf_wen); else n_pass++;
    tick();
  endtask

  task automatic test_scoreboard();
    rd_addr1 = 9; issue_mdu = 1; issue_waddr = 9; #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL sb_pre got=%0b exp=0", hazard); else n_pass++;
    tick(); issue_mdu = 0; mdu_valid = 1; mdu_waddr = 9; mdu_wdata = 32'h99; #1;
    n_checks++; if (hazard !== SB) $display("FAIL sb_busy got=%0b exp=%0b", hazard, SB); else n_pass++;
    tick(); mdu_valid = 0; issue_mdu = 1; issue_waddr = 9; #1;
    n_checks++; if (hazard !== SB || rf_wen !== 1'b1 || rf_waddr !== 5'd9)
      $display("FAIL sb_drain1 haz=%0b wen=%0b addr=%0d exp=%0b/1/9", hazard, rf_wen, rf_waddr, SB); else n_pass++;
    tick(); issue_mdu = 0; mdu_valid = 1; mdu_waddr = 9; mdu_wdata = 32'h9A; #1;
    n_checks++; if (hazard !== SB) $display("FAIL sb_reissue got=%0b exp=%0b", hazard, SB); else n_pass++;
    tick(); mdu_valid = 0; #1;
    n_checks++; if (hazard !== SB || rf_wen !== 1'b1) $display("FAIL sb_drain2 haz=%0b wen=%0b exp=%0b/1", hazard, rf_wen, SB); else n_pass++;
    tick(); #1;
    n_checks++; if (hazard !== 1'b0) $display("FAIL sb_clear got=%0b exp=0", hazard); else n_pass++;
    idle_inputs(); tick();
  endtask

  task automatic test_reset_force();
    wb_reg_wen = 1; wb_reg_waddr = 4; wb_reg_wdata = 32'h44;
    mdu_valid = 1; mdu_waddr = 10; mdu_wdata = 32'hAA;
    tick(); mdu_valid = 0;
    for (int c = 0; c < LIMIT; c++) tick();
    #1;
    n_checks++; if (stall_req !== 1'b1) $display("FAIL rstf_force got=%0b exp=1", stall_req); else n_pass++;
    rst = 0; #1;
    n_checks++; if ({stall_req, mdu_ready, rf_wen} !== 3'b000)
      $display("FAIL rstf_during got=%0b%0b%0b exp=000", stall_req, mdu_ready, rf_wen); else n_pass++;
    tick(); rst = 1; wb_reg_wen = 0; #1;
    n_checks++; if ({stall_req, mdu_ready, rf_wen} !== 3'b010)
      $display("FAIL rstf_after got=%0b%0b%0b exp=010", stall_req, mdu_ready, rf_wen); else n_pass++;
    tick(); #1;
    n_checks++; if (rf_wen !== 1'b0) $display("FAIL rstf_no_write got=%0b exp=0", rf_wen); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rst          = ($urandom_range(0, 99) >= 2);
      wb_reg_wen   = ($urandom_range(0, 99) < 65);
      wb_reg_waddr = 5'($urandom_range(0, 7));
      wb_reg_wdata = $urandom;
      mdu_valid    = $urandom_range(0, 1);
      mdu_waddr    = 5'($urandom_range(0, 7));
      mdu_wdata    = $urandom;
      issue_mdu    = ($urandom_range(0, 99) < 25);
      issue_waddr  = 5'($urandom_range(0, 7));
      rd_addr1     = 5'($urandom_range(0, 7));
      rd_addr2     = 5'($urandom_range(0, 7));
      #1;
      model_eval();
      n_checks++;
      if ({mdu_ready, stall_req, hazard, rf_wen, rf_waddr, rf_wdata} !==
          {e_ready, e_stall, e_haz, e_wen, e_waddr, e_wdata})
        $display("FAIL rand c=%0d got rdy=%0b stl=%0b haz=%0b wen=%0b a=%0d d=%h exp rdy=%0b stl=%0b haz=%0b wen=%0b a=%0d d=%h",
                 c, mdu_ready, stall_req, hazard, rf_wen, rf_waddr, rf_wdata,
                 e_ready, e_stall, e_haz, e_wen, e_waddr, e_wdata);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_mdu_only();
    test_collision();
    test_starvation();
    test_x0();
    test_scoreboard();
    test_reset_force();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
